// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   - FSM state codes (2-bit, legacy-compatible constants)
//   - BCD / segment constants
//   - seg7_decode: BCD digit -> active-low {g,f,e,d,c,b,a}
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_ZERO = 7'h40;

  // Active-low segments, bit order {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
  function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Raw push-button conditioner.
//   clk, rst : system clock, async active-high reset
//   btn      : raw button level (asynchronous to clk)
//   press    : one-cycle pulse on each 0->1 change of the debounced level
// The debounced level only follows the synchronized input once the two have
// disagreed for DEB_CYC consecutive cycles; any agreement restarts the count.
module btn_debounce #(
  parameter logic [31:0] DEB_CYC = 32'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEB_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 32'd1);

  logic          s1, s2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      press <= 1'b0;
      if (s2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= s2;
          cnt   <= '0;
          // Pulse lines up with the level's rising edge.
          press <= s2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Two-digit (00..99) stopwatch controller.
//   clk, rst            : system clock, async active-high reset
//   btn_ss/clr/lap      : raw start-stop / clear / lap buttons
//   tens, ones          : displayed BCD digits (live count or frozen lap value)
//   seg_tens, seg_ones  : registered active-low 7-segment patterns of tens/ones
//   running             : state is RUN
//   lap_active          : display frozen at the lap register
//   tick_o              : one-cycle pulse per count increment
//   wrap_o              : one-cycle pulse when the count rolls 99 -> 00
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter logic [31:0] TICK_DIV = 32'd50_000_000,
  parameter logic [31:0] DEB_CYC  = 32'd1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  input  logic       btn_lap,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic       running,
  output logic       lap_active,
  output logic       tick_o,
  output logic       wrap_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 32'd1);

  // ---------------------------------------------------------------- buttons
  logic ev_ss, ev_clr, ev_lap;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_ss  (.clk(clk), .rst(rst), .btn(btn_ss),  .press(ev_ss));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_clr (.clk(clk), .rst(rst), .btn(btn_clr), .press(ev_clr));
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_lap (.clk(clk), .rst(rst), .btn(btn_lap), .press(ev_lap));

  // ---------------------------------------------------------------- FSM
  logic [1:0] state, state_nxt;
  logic       go_idle, lap_set, lap_clr;

  // Within each state only events that are meaningful there are considered,
  // so a lower-priority event still acts if every higher one is meaningless.
  always_comb begin
    state_nxt = state;
    go_idle   = 1'b0;
    lap_set   = 1'b0;
    lap_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ev_ss) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (ev_ss) begin
          state_nxt = ST_PAUSE;
        end else if (ev_lap) begin
          lap_set = ~lap_active;
          lap_clr = lap_active;
        end
      end
      ST_PAUSE: begin
        if (ev_clr) begin
          state_nxt = ST_IDLE;
          go_idle   = 1'b1;
        end else if (ev_ss) begin
          state_nxt = ST_RUN;
        end else if (ev_lap && lap_active) begin
          lap_clr = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        go_idle   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  assign running = (state == ST_RUN);

  // ---------------------------------------------------------------- prescaler
  // Frozen outside RUN so a resume continues the partial period.
  logic [PW-1:0] presc;

  assign tick_o = running && (presc == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (go_idle) begin
      presc <= '0;
    end else if (running) begin
      presc <= tick_o ? '0 : presc + PW'(1);
    end
  end

  // ---------------------------------------------------------------- BCD count
  logic [3:0] cnt_t, cnt_o;

  assign wrap_o = tick_o && (cnt_t == BCD_MAX) && (cnt_o == BCD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_t <= 4'd0;
      cnt_o <= 4'd0;
    end else if (go_idle) begin
      cnt_t <= 4'd0;
      cnt_o <= 4'd0;
    end else if (tick_o) begin
      if (cnt_o == BCD_MAX) begin
        cnt_o <= 4'd0;
        cnt_t <= (cnt_t == BCD_MAX) ? 4'd0 : cnt_t + 4'd1;
      end else begin
        cnt_o <= cnt_o + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------- lap
  // Latches the pre-increment count if a tick lands on the same edge.
  logic [3:0] lap_t, lap_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_active <= 1'b0;
      lap_t      <= 4'd0;
      lap_o      <= 4'd0;
    end else if (go_idle || lap_clr) begin
      lap_active <= 1'b0;
    end else if (lap_set) begin
      lap_active <= 1'b1;
      lap_t      <= cnt_t;
      lap_o      <= cnt_o;
    end
  end

  // ---------------------------------------------------------------- display
  assign tens = lap_active ? lap_t : cnt_t;
  assign ones = lap_active ? lap_o : cnt_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_tens <= SEG_ZERO;
      seg_ones <= SEG_ZERO;
    end else begin
      seg_tens <= seg7_decode(tens);
      seg_ones <= seg7_decode(ones);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (TICK_DIV=4, DEB_CYC=3).
// Directed scenarios plus randomized button/reset stimulus, all compared each
// cycle against a behavioural model of the stopwatch.
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_ss = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;
  logic [3:0] tens, ones;
  logic [6:0] seg_tens, seg_ones;
  logic       running, lap_active, tick_o, wrap_o;

  stopwatch_ctrl #(.TICK_DIV(32'd4), .DEB_CYC(32'd3)) dut (
    .clk(clk), .rst(rst),
    .btn_ss(btn_ss), .btn_clr(btn_clr), .btn_lap(btn_lap),
    .tens(tens), .ones(ones), .seg_tens(seg_tens), .seg_ones(seg_ones),
    .running(running), .lap_active(lap_active), .tick_o(tick_o), .wrap_o(wrap_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_no = 0;
  int tick_seen = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc_no);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int         m_cnt, m_presc, m_lapv;
  bit         m_run, m_pause, m_lap;
  logic [6:0] m_segt, m_sego;
  // Per button (0 clr, 1 ss, 2 lap): raw samples newest at bit 0, debounced
  // level, and press pulse currently visible.
  logic [DC+1:0] hist [3];
  bit            deb  [3];
  bit            prs  [3];

  task automatic model_reset();
    m_cnt = 0; m_presc = 0; m_lapv = 0;
    m_run = 0; m_pause = 0; m_lap = 0;
    m_segt = 7'h40; m_sego = 7'h40;
    for (int i = 0; i < 3; i++) begin
      hist[i] = '0; deb[i] = 0; prs[i] = 0;
    end
  endtask

  function automatic int m_disp();
    return m_lap ? m_lapv : m_cnt;
  endfunction

  task automatic model_step();
    bit tk;
    int old;
    bit raw [3];
    bit np [3];
    raw[0] = btn_clr; raw[1] = btn_ss; raw[2] = btn_lap;
    tk  = m_run && (m_presc == TD - 1);
    old = m_cnt;
    m_segt = seg_tbl[m_disp() / 10];
    m_sego = seg_tbl[m_disp() % 10];
    if (m_run) m_presc = tk ? 0 : m_presc + 1;
    if (tk) m_cnt = (m_cnt + 1) % 100;
    if (!m_run && !m_pause) begin
      if (prs[1]) m_run = 1;
    end else if (m_run) begin
      if (prs[1]) begin
        m_run = 0; m_pause = 1;
      end else if (prs[2]) begin
        if (!m_lap) m_lapv = old;
        m_lap = !m_lap;
      end
    end else begin
      if (prs[0]) begin
        m_pause = 0; m_cnt = 0; m_presc = 0; m_lap = 0;
      end else if (prs[1]) begin
        m_pause = 0; m_run = 1;
      end else if (prs[2] && m_lap) begin
        m_lap = 0;
      end
    end
    // A sample reaches the debouncer two edges after capture; the level flips
    // once the last DC such samples all disagree with it.
    for (int i = 0; i < 3; i++) begin
      hist[i] = {hist[i][DC:0], raw[i]};
      np[i] = 0;
      if (!deb[i] && (&hist[i][DC+1:2])) begin
        deb[i] = 1; np[i] = 1;
      end else if (deb[i] && !(|hist[i][DC+1:2])) begin
        deb[i] = 0;
      end
      prs[i] = np[i];
    end
  endtask

  task automatic check_all();
    bit tk;
    tk = m_run && (m_presc == TD - 1);
    chk("tens", tens, m_disp() / 10);
    chk("ones", ones, m_disp() % 10);
    chk("seg_tens", seg_tens, m_segt);
    chk("seg_ones", seg_ones, m_sego);
    chk("running", running, m_run);
    chk("lap_active", lap_active, m_lap);
    chk("tick_o", tick_o, tk);
    chk("wrap_o", wrap_o, tk && (m_cnt == 99));
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      cyc_no++;
      check_all();
      if (tick_o) tick_seen++;
    end
  endtask

  task automatic do_reset(input int hold);
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    cyc(hold);
    rst = 1'b0;
  endtask

  task automatic push(input int b, input int hold, input int gap);
    {btn_lap, btn_ss, btn_clr} = 3'(b);
    cyc(hold);
    {btn_lap, btn_ss, btn_clr} = 3'b000;
    cyc(gap);
  endtask

  int t0, last, n;

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_all();
    chk("rst_seg_tens", seg_tens, 7'h40);
    @(negedge clk);
    cyc(2);
    rst = 1'b0;

    // Start from IDLE with a long press; count ticks and their spacing.
    t0 = tick_seen;
    push(3'b010, 10, 0);
    chk("ss_started", running, 1);
    last = -1;
    for (int k = 0; k < 200 && tick_seen - t0 < 12; k++) begin
      cyc(1);
      if (tick_o) begin
        if (last >= 0) chk("tick_period", cyc_no - last, TD);
        last = cyc_no;
      end
    end
    chk("twelve_ticks", tick_seen - t0, 12);
    cyc(1);
    chk("count12_tens", tens, 1);
    chk("count12_ones", ones, 2);

    // Roll over 99 -> 00.
    for (int k = 0; k < 600 && !(tens == 9 && ones == 9); k++) cyc(1);
    chk("reach_99", {tens, ones}, 8'h99);
    for (int k = 0; k < 10 && !tick_o; k++) cyc(1);
    chk("wrap_tick", tick_o, 1);
    chk("wrap_pulse", wrap_o, 1);
    cyc(1);
    chk("wrap_single", wrap_o, 0);
    chk("wrap_to_00", {tens, ones}, 8'h00);

    // Asynchronous reset in the middle of a run at 37.
    for (int k = 0; k < 400 && !(tens == 3 && ones == 7); k++) cyc(1);
    chk("reach_37", {tens, ones}, 8'h37);
    #2;
    do_reset(2);
    chk("rst_tens", tens, 0);
    chk("rst_ones", ones, 0);
    chk("rst_seg", seg_ones, 7'h40);
    chk("rst_running", running, 0);
    chk("rst_tick", tick_o, 0);

    // Pause with prescaler at 2 at count 03, then resume.
    push(3'b010, 4, 6);
    for (int k = 0; k < 100 && !(m_run && m_cnt == 2 && m_presc == 0); k++) cyc(1);
    push(3'b010, 4, 4);
    chk("paused", running, 0);
    chk("paused_at_03", {tens, ones}, 8'h03);
    cyc(6);
    btn_ss = 1'b1;
    for (int k = 0; k < 20 && !running; k++) cyc(1);
    chk("resumed", running, 1);
    n = 1;
    for (int k = 0; k < 10 && !tick_o; k++) begin
      cyc(1);
      n++;
    end
    chk("resume_tick_gap", n, 2);
    cyc(1);
    chk("resume_count_04", {tens, ones}, 8'h04);
    btn_ss = 1'b0;

    // Lap freeze at 05 while the live count moves on to 08.
    for (int k = 0; k < 50 && !(m_cnt == 4 && m_presc == 2); k++) cyc(1);
    push(3'b100, 4, 2);
    chk("lap_on", lap_active, 1);
    chk("lap_hold_05", {tens, ones}, 8'h05);
    for (int k = 0; k < 50 && !(m_cnt == 7 && m_presc == 1); k++) cyc(1);
    chk("lap_still_05", {tens, ones}, 8'h05);
    push(3'b100, 4, 0);
    chk("lap_live_08_hidden", {tens, ones}, 8'h05);
    cyc(2);
    chk("lap_off", lap_active, 0);
    chk("lap_release_08", {tens, ones}, 8'h08);
    cyc(6);

    // Clear ignored in RUN; short ss glitches dropped.
    push(3'b001, 4, 8);
    chk("clr_in_run", running, 1);
    push(3'b010, 1, 6);
    push(3'b010, 2, 6);
    chk("glitch_no_press", running, 1);
    // Pause, then clr and ss together: clear wins.
    push(3'b010, 4, 8);
    chk("pause_again", running, 0);
    push(3'b011, 4, 8);
    chk("clr_ss_idle", running, 0);
    chk("clr_ss_00", {tens, ones}, 8'h00);
    chk("clr_ss_lap", lap_active, 0);

    // Randomized buttons with occasional mid-run resets.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        {btn_lap, btn_ss, btn_clr} = 3'($urandom_range(0, 7));
        do_reset($urandom_range(1, 3));
      end
      push($urandom_range(0, 7), $urandom_range(1, 8), $urandom_range(0, 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
